// File: rtl/u_hz_ctl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Stage masks are built at the widest supported pipeline and truncated by users.
package hz_pkg;

    // Controller operating modes
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BRDRN  = 2'd1,
        MCWAIT = 2'd2
    } hz_st_e;

    // Fixed stage indices: stage 0 is the IFU, stage 1 the first execute stage
    localparam int STG_IFU  = 0;
    localparam int STG_EX0  = 1;

    // Widest pipeline supported and the index width that covers it plus one
    localparam int MAX_NSTG = 8;
    localparam int IDX_W    = 4;

    // Ones for stages 0..idx (inclusive)
    function automatic logic [MAX_NSTG-1:0] stg_mask(input logic [IDX_W-1:0] idx);
        logic [MAX_NSTG-1:0] m;
        for (int i = 0; i < MAX_NSTG; i++) begin
            if (IDX_W'(i) <= idx) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // One-hot stage bit; index MAX_NSTG lands in the extra top bit so that
    // "stage after the last one" simply falls off when truncated
    function automatic logic [MAX_NSTG:0] stg_bit(input logic [IDX_W-1:0] idx);
        logic [MAX_NSTG:0] b;
        for (int i = 0; i <= MAX_NSTG; i++) begin
            if (IDX_W'(i) == idx) begin
                b[i] = 1'b1;
            end else begin
                b[i] = 1'b0;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/u_hz_ctl_if.sv
// Hazard event / control bundle between the pipeline and the hazard controller.
// master = pipeline side raising events, slave = hazard controller.
interface u_hz_ctl_if #(
    parameter int NSTG = 4,
    parameter int SW   = $clog2(NSTG),
    parameter int CW   = 16
);
    logic            ifu_vld;
    logic            br_vld;
    logic [SW-1:0]   br_stg;
    logic            fwd_no_dat;
    logic [SW-1:0]   fwd_stg;
    logic            mc_start;
    logic            mc_done;
    logic            cnt_clr;
    logic [NSTG-1:0] hzf;
    logic [NSTG-1:0] hzs;
    logic            mc_kill;
    logic            mc_tmo;
    logic [CW-1:0]   stl_cyc;

    modport master (
        output ifu_vld, br_vld, br_stg, fwd_no_dat, fwd_stg,
               mc_start, mc_done, cnt_clr,
        input  hzf, hzs, mc_kill, mc_tmo, stl_cyc
    );

    modport slave (
        input  ifu_vld, br_vld, br_stg, fwd_no_dat, fwd_stg,
               mc_start, mc_done, cnt_clr,
        output hzf, hzs, mc_kill, mc_tmo, stl_cyc
    );
endinterface

// File: rtl/u_hz_ctl_chk.sv
// Protocol checker for the hazard controller: flags branches resolved
// upstream of the multi-cycle unit while it is waiting, and any stage
// that is both flushed and held.
module u_hz_ctl_chk #(
    parameter int NSTG = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            i_mcwait,
    input logic            i_br_vld,
    input logic            i_br_low,
    input logic [NSTG-1:0] i_hzf,
    input logic [NSTG-1:0] i_hzs
);

    // A branch older than the multi-cycle op cannot resolve while it waits
    a_br_in_mcwait: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_mcwait && i_br_vld && i_br_low))
        else $error("u_hz_ctl: branch resolved upstream of the multi-cycle stage during wait");

    // Flush always wins over hold on the same stage
    a_flush_dom: assert property (@(posedge clk) disable iff (!rst_n)
        ((i_hzf & i_hzs) == '0))
        else $error("u_hz_ctl: stage both flushed and held");

endmodule

// File: rtl/u_hz_ctl.sv
// Pipeline hazard controller: per-stage flush/hold vectors with branch
// wrong-path drain, multi-cycle-unit wait with watchdog, and a saturating
// count of front-end stall cycles.
module u_hz_ctl
    import hz_pkg::*;
#(
    parameter int NSTG   = 4,
    parameter int SW     = $clog2(NSTG),
    parameter int MC_STG = 2,
    parameter int BR_PEN = 1,
    parameter int MC_TMO = 64,
    parameter int CW     = 16
) (
    input logic       clk,
    input logic       rst_n,
    u_hz_ctl_if.slave hz
);

    localparam int             WCW     = $clog2(MC_TMO);
    localparam logic [2:0]     PEN     = 3'(BR_PEN);
    localparam logic [WCW-1:0] WD_LAST = WCW'(MC_TMO - 1);

    hz_st_e          r_state;
    hz_st_e          w_nxt_state;
    logic [2:0]      r_dcnt;
    logic [2:0]      w_nxt_dcnt;
    logic [WCW-1:0]  r_wcnt;
    logic [WCW-1:0]  w_nxt_wcnt;
    logic [CW-1:0]   r_stl;

    logic [SW-1:0]   w_br_stg;
    logic [SW-1:0]   w_fwd_stg;
    logic [NSTG-1:0] w_br_mask;
    logic [NSTG-1:0] w_fwd_mask;
    logic [NSTG-1:0] w_fwd_bit;
    logic [NSTG-1:0] w_mc_mask;
    logic [NSTG-1:0] w_mc_bit;
    logic [NSTG-1:0] w_ifu_bit;
    logic [NSTG-1:0] w_ex_bit;
    logic            w_br_ok;
    logic            w_br_low;
    logic            w_wd_exp;
    logic            w_fwd_late;

    logic [NSTG-1:0] w_hzf;
    logic [NSTG-1:0] w_hzs_raw;
    logic [NSTG-1:0] w_hzs;
    logic            w_kill;
    logic            w_tmo;

    // Stage-index decode into masks and one-hot bits
    assign w_br_stg   = hz.br_stg;
    assign w_fwd_stg  = hz.fwd_stg;
    assign w_br_mask  = NSTG'(stg_mask(IDX_W'(w_br_stg)));
    assign w_fwd_mask = NSTG'(stg_mask(IDX_W'(w_fwd_stg)));
    assign w_fwd_bit  = NSTG'(stg_bit(IDX_W'(w_fwd_stg) + IDX_W'(1)));
    assign w_mc_mask  = NSTG'(stg_mask(IDX_W'(MC_STG)));
    assign w_mc_bit   = NSTG'(stg_bit(IDX_W'(MC_STG + 1)));
    assign w_ifu_bit  = NSTG'(stg_bit(IDX_W'(STG_IFU)));
    assign w_ex_bit   = NSTG'(stg_bit(IDX_W'(STG_EX0)));

    // Branch at or past the multi-cycle stage can legally kill the waiting op
    assign w_br_ok    = hz.br_vld && (IDX_W'(w_br_stg) >= IDX_W'(MC_STG));
    assign w_br_low   = (IDX_W'(w_br_stg) < IDX_W'(MC_STG));
    assign w_wd_exp   = (r_wcnt == WD_LAST);
    // During drain stage 0 is already flushed, so only downstream consumers matter
    assign w_fwd_late = hz.fwd_no_dat && (IDX_W'(w_fwd_stg) != IDX_W'(STG_IFU));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Drain and watchdog counters, owned by the state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt <= 3'd0;
            r_wcnt <= '0;
        end else begin
            r_dcnt <= w_nxt_dcnt;
            r_wcnt <= w_nxt_wcnt;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_dcnt  = r_dcnt;
        w_nxt_wcnt  = r_wcnt;
        case (r_state)
            RUN: begin
                if (hz.br_vld) begin
                    if (BR_PEN > 0) begin
                        w_nxt_state = BRDRN;
                        w_nxt_dcnt  = PEN;
                    end else begin
                        w_nxt_state = RUN;
                        w_nxt_dcnt  = 3'd0;
                    end
                end else if (hz.mc_start && !hz.mc_done) begin
                    w_nxt_state = MCWAIT;
                    w_nxt_wcnt  = '0;
                end else begin
                    w_nxt_state = RUN;
                end
            end
            BRDRN: begin
                if (hz.br_vld) begin
                    w_nxt_state = BRDRN;
                    w_nxt_dcnt  = PEN;
                end else if (r_dcnt <= 3'd1) begin
                    w_nxt_state = RUN;
                    w_nxt_dcnt  = 3'd0;
                end else begin
                    w_nxt_state = BRDRN;
                    w_nxt_dcnt  = r_dcnt - 3'd1;
                end
            end
            MCWAIT: begin
                if (w_br_ok) begin
                    w_nxt_wcnt = '0;
                    if (BR_PEN > 0) begin
                        w_nxt_state = BRDRN;
                        w_nxt_dcnt  = PEN;
                    end else begin
                        w_nxt_state = RUN;
                        w_nxt_dcnt  = 3'd0;
                    end
                end else if (hz.mc_done || w_wd_exp) begin
                    w_nxt_state = RUN;
                    w_nxt_wcnt  = '0;
                end else begin
                    w_nxt_state = MCWAIT;
                    w_nxt_wcnt  = r_wcnt + WCW'(1);
                end
            end
            default: begin
                w_nxt_state = RUN;
                w_nxt_dcnt  = 3'd0;
                w_nxt_wcnt  = '0;
            end
        endcase
    end

    // Flush/hold/kill decode from the current state and this cycle's events
    always_comb begin
        w_hzf     = '0;
        w_hzs_raw = '0;
        w_kill    = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            RUN: begin
                if (hz.br_vld) begin
                    w_hzf = w_br_mask;
                end else if (hz.mc_start) begin
                    w_hzs_raw = w_mc_mask;
                    w_hzf     = w_mc_bit;
                end else if (hz.fwd_no_dat) begin
                    w_hzs_raw = w_fwd_mask;
                    w_hzf     = w_fwd_bit;
                end else if (!hz.ifu_vld) begin
                    w_hzf = w_ex_bit;
                end else begin
                    w_hzf = '0;
                end
            end
            BRDRN: begin
                if (hz.br_vld) begin
                    w_hzf = w_br_mask | w_ifu_bit;
                end else if (w_fwd_late) begin
                    w_hzs_raw = w_fwd_mask & ~w_ifu_bit;
                    w_hzf     = w_fwd_bit | w_ifu_bit;
                end else begin
                    w_hzf = w_ifu_bit;
                end
            end
            MCWAIT: begin
                if (w_br_ok) begin
                    w_hzf  = w_br_mask;
                    w_kill = 1'b1;
                end else if (hz.mc_done || w_wd_exp) begin
                    // Op finished or abandoned: no MC hold, ordinary hazards apply
                    w_kill = !hz.mc_done;
                    w_tmo  = !hz.mc_done;
                    if (hz.fwd_no_dat) begin
                        w_hzs_raw = w_fwd_mask;
                        w_hzf     = w_fwd_bit;
                    end else if (!hz.ifu_vld) begin
                        w_hzf = w_ex_bit;
                    end else begin
                        w_hzf = '0;
                    end
                end else begin
                    w_hzs_raw = w_mc_mask;
                    w_hzf     = w_mc_bit;
                end
            end
            default: begin
                w_hzf     = '0;
                w_hzs_raw = '0;
            end
        endcase
    end

    // Flush dominates hold per stage
    assign w_hzs = w_hzs_raw & ~w_hzf;

    // Saturating count of front-end stall cycles, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stl <= '0;
        end else if (hz.cnt_clr) begin
            r_stl <= '0;
        end else if (w_hzs[STG_IFU] && (r_stl != '1)) begin
            r_stl <= r_stl + CW'(1);
        end else begin
            r_stl <= r_stl;
        end
    end

    assign hz.hzf     = w_hzf;
    assign hz.hzs     = w_hzs;
    assign hz.mc_kill = w_kill;
    assign hz.mc_tmo  = w_tmo;
    assign hz.stl_cyc = r_stl;

    u_hz_ctl_chk #(
        .NSTG (NSTG)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_mcwait (r_state == MCWAIT),
        .i_br_vld (hz.br_vld),
        .i_br_low (w_br_low),
        .i_hzf    (w_hzf),
        .i_hzs    (w_hzs)
    );

endmodule

// File: tb/tb_u_hz_ctl.sv
// Self-checking bench for u_hz_ctl: directed scenarios plus randomized
// traffic against a behavioural model of the hazard rules.
module tb_u_hz_ctl;

    localparam int NSTG   = 4;
    localparam int SW     = 2;
    localparam int MC_STG = 2;
    localparam int BR_PEN = 2;
    localparam int MC_TMO = 8;
    localparam int CW     = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    u_hz_ctl_if #(.NSTG(NSTG), .SW(SW), .CW(CW)) hzi ();

    u_hz_ctl #(
        .NSTG(NSTG), .SW(SW), .MC_STG(MC_STG), .BR_PEN(BR_PEN),
        .MC_TMO(MC_TMO), .CW(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hzi)
    );

    // Observed {hzf, hzs, mc_kill, mc_tmo}
    wire [2*NSTG+1:0] w_obs = {hzi.hzf, hzi.hzs, hzi.mc_kill, hzi.mc_tmo};

    int n_chk  = 0;
    int n_fail = 0;
    logic [2*NSTG+1:0] e;

    // Behavioural model: cycles of stage-0 flush still owed, age of the
    // pending multi-cycle op (-1 = none), and the stall count
    int m_drain;
    int m_wait;
    int m_stl;
    logic [NSTG-1:0] m_f, m_s;
    logic m_k, m_t;

    function automatic int upto(input int n);
        return (1 << (n + 1)) - 1;
    endfunction

    task automatic model_eval();
        int f, s, bs, fs;
        bit gen;
        f = 0; s = 0; gen = 0; m_k = 1'b0; m_t = 1'b0;
        bs = int'(hzi.br_stg);
        fs = int'(hzi.fwd_stg);
        if (m_wait >= 0) begin
            if (hzi.br_vld && bs >= MC_STG) begin
                f = upto(bs); m_k = 1'b1;
            end else if (hzi.mc_done) begin
                gen = 1;
            end else if (m_wait == MC_TMO - 1) begin
                m_k = 1'b1; m_t = 1'b1; gen = 1;
            end else begin
                s = upto(MC_STG); f = 1 << (MC_STG + 1);
            end
        end else if (m_drain > 0) begin
            f = 1;
            if (hzi.br_vld) f = f | upto(bs);
            else if (hzi.fwd_no_dat && fs >= 1) begin
                s = upto(fs) - 1; f = f | (1 << (fs + 1));
            end
        end else begin
            if (hzi.br_vld) f = upto(bs);
            else if (hzi.mc_start) begin
                s = upto(MC_STG); f = 1 << (MC_STG + 1);
            end else gen = 1;
        end
        if (gen) begin
            if (hzi.fwd_no_dat) begin
                s = upto(fs); f = f | (1 << (fs + 1));
            end else if (!hzi.ifu_vld) f = f | 2;
        end
        f = f & ((1 << NSTG) - 1);
        s = s & ~f;
        m_f = f[NSTG-1:0];
        m_s = s[NSTG-1:0];
    endtask

    task automatic model_adv();
        if (hzi.cnt_clr) m_stl = 0;
        else if (m_s[0] && m_stl < (1 << CW) - 1) m_stl = m_stl + 1;
        if (m_wait >= 0) begin
            if (hzi.br_vld && int'(hzi.br_stg) >= MC_STG) begin
                m_wait = -1; m_drain = BR_PEN;
            end else if (hzi.mc_done || m_wait == MC_TMO - 1) m_wait = -1;
            else m_wait = m_wait + 1;
        end else if (m_drain > 0) begin
            if (hzi.br_vld) m_drain = BR_PEN;
            else m_drain = m_drain - 1;
        end else begin
            if (hzi.br_vld) m_drain = BR_PEN;
            else if (hzi.mc_start && !hzi.mc_done) m_wait = 0;
        end
    endtask

    task automatic idle();
        hzi.ifu_vld = 1'b1; hzi.br_vld = 1'b0; hzi.br_stg = '0;
        hzi.fwd_no_dat = 1'b0; hzi.fwd_stg = '0; hzi.mc_start = 1'b0;
        hzi.mc_done = 1'b0; hzi.cnt_clr = 1'b0;
    endtask

    task automatic clk_edge();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle(); hzi.ifu_vld = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        e = {4'b0010, 4'b0000, 2'b00};
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL reset_out got %b want %b", w_obs, e); end
        n_chk++; if (hzi.stl_cyc !== 16'd0) begin n_fail++; $display("FAIL reset_stl got %0d want 0", hzi.stl_cyc); end
        clk_edge(); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL reset_release got %b want %b", w_obs, e); end
        hzi.ifu_vld = 1'b1;
    endtask

    task automatic test_branch();
        do_reset();
        hzi.br_vld = 1'b1; hzi.br_stg = 2'd1;
        @(negedge clk); e = {4'b0011, 4'b0000, 2'b00};
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL br_first got %b want %b", w_obs, e); end
        clk_edge(); hzi.br_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); e = {4'b0001, 4'b0000, 2'b00};
            n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL br_drain%0d got %b want %b", k, w_obs, e); end
            clk_edge();
        end
        @(negedge clk); e = '0;
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL br_done got %b want %b", w_obs, e); end
    endtask

    task automatic test_fwd();
        do_reset();
        hzi.fwd_no_dat = 1'b1; hzi.fwd_stg = 2'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); e = {4'b0100, 4'b0011, 2'b00};
            n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL fwd_stall%0d got %b want %b", k, w_obs, e); end
            clk_edge();
        end
        hzi.fwd_no_dat = 1'b0;
        @(negedge clk);
        n_chk++; if (hzi.stl_cyc !== 16'd3) begin n_fail++; $display("FAIL fwd_stl got %0d want 3", hzi.stl_cyc); end
        hzi.fwd_no_dat = 1'b1; hzi.fwd_stg = 2'd3;
        #1; e = {4'b0000, 4'b1111, 2'b00};
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL fwd_last got %b want %b", w_obs, e); end
        clk_edge(); hzi.fwd_no_dat = 1'b0;
    endtask

    task automatic test_mc_done();
        do_reset();
        hzi.mc_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); e = {4'b1000, 4'b0111, 2'b00};
            n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL mc_hold%0d got %b want %b", k, w_obs, e); end
            clk_edge(); hzi.mc_start = 1'b0;
        end
        hzi.mc_done = 1'b1;
        @(negedge clk); e = '0;
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL mc_done_cyc got %b want %b", w_obs, e); end
        clk_edge(); hzi.mc_done = 1'b0;
        @(negedge clk);
        n_chk++; if (hzi.stl_cyc !== 16'd5) begin n_fail++; $display("FAIL mc_stl got %0d want 5", hzi.stl_cyc); end
        // single-cycle op: stalls for its own cycle only
        hzi.mc_start = 1'b1; hzi.mc_done = 1'b1;
        #1; e = {4'b1000, 4'b0111, 2'b00};
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL mc_single got %b want %b", w_obs, e); end
        clk_edge(); hzi.mc_start = 1'b0; hzi.mc_done = 1'b0;
        @(negedge clk); e = '0;
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL mc_single_after got %b want %b", w_obs, e); end
    endtask

    task automatic test_mc_tmo();
        do_reset();
        hzi.mc_start = 1'b1;
        @(negedge clk); clk_edge(); hzi.mc_start = 1'b0;
        for (int k = 0; k < MC_TMO - 1; k++) begin
            @(negedge clk); e = {4'b1000, 4'b0111, 2'b00};
            n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL tmo_hold%0d got %b want %b", k, w_obs, e); end
            clk_edge();
        end
        @(negedge clk); e = {4'b0000, 4'b0000, 2'b11};
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL tmo_pulse got %b want %b", w_obs, e); end
        clk_edge();
        @(negedge clk); e = '0;
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL tmo_after got %b want %b", w_obs, e); end
        n_chk++; if (hzi.stl_cyc !== 16'd8) begin n_fail++; $display("FAIL tmo_stl got %0d want 8", hzi.stl_cyc); end
    endtask

    task automatic test_mc_branch();
        do_reset();
        hzi.mc_start = 1'b1;
        @(negedge clk); clk_edge(); hzi.mc_start = 1'b0;
        @(negedge clk); clk_edge();
        hzi.br_vld = 1'b1; hzi.br_stg = 2'd3;
        @(negedge clk); e = {4'b1111, 4'b0000, 2'b10};
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL mcbr_kill got %b want %b", w_obs, e); end
        clk_edge(); hzi.br_vld = 1'b0;
        for (int k = 0; k < BR_PEN; k++) begin
            @(negedge clk); e = {4'b0001, 4'b0000, 2'b00};
            n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL mcbr_drain%0d got %b want %b", k, w_obs, e); end
            clk_edge();
        end
        @(negedge clk); e = '0;
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL mcbr_done got %b want %b", w_obs, e); end
    endtask

    task automatic test_sat_clr();
        do_reset();
        hzi.fwd_no_dat = 1'b1; hzi.fwd_stg = 2'd0;
        repeat (65535) @(posedge clk);
        #1; @(negedge clk);
        n_chk++; if (hzi.stl_cyc !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h want ffff", hzi.stl_cyc); end
        clk_edge(); @(negedge clk);
        n_chk++; if (hzi.stl_cyc !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", hzi.stl_cyc); end
        hzi.cnt_clr = 1'b1;
        clk_edge(); hzi.cnt_clr = 1'b0; @(negedge clk);
        n_chk++; if (hzi.stl_cyc !== 16'h0000) begin n_fail++; $display("FAIL clr got %h want 0000", hzi.stl_cyc); end
        clk_edge(); @(negedge clk);
        n_chk++; if (hzi.stl_cyc !== 16'h0001) begin n_fail++; $display("FAIL clr_resume got %h want 0001", hzi.stl_cyc); end
        hzi.fwd_no_dat = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        hzi.mc_start = 1'b1;
        @(negedge clk); clk_edge(); hzi.mc_start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); e = '0;
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL rst_mcwait got %b want %b", w_obs, e); end
        clk_edge(); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL rst_mcwait_after got %b want %b", w_obs, e); end
        clk_edge();
        hzi.br_vld = 1'b1; hzi.br_stg = 2'd2;
        @(negedge clk); clk_edge(); hzi.br_vld = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL rst_brdrn got %b want %b", w_obs, e); end
        clk_edge(); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL rst_brdrn_after got %b want %b", w_obs, e); end
    endtask

    task automatic test_random();
        do_reset();
        m_drain = 0; m_wait = -1; m_stl = 0;
        for (int c = 0; c < 800; c++) begin
            hzi.br_vld     = ($urandom_range(0, 7) == 0);
            hzi.br_stg     = SW'($urandom_range(0, NSTG - 1));
            if (m_wait >= 0 && int'(hzi.br_stg) < MC_STG)
                hzi.br_stg = SW'(MC_STG + $urandom_range(0, 1));
            hzi.mc_start   = (m_wait < 0) && (m_drain == 0) && ($urandom_range(0, 5) == 0);
            hzi.mc_done    = ($urandom_range(0, 9) == 0);
            hzi.fwd_no_dat = ($urandom_range(0, 3) == 0);
            hzi.fwd_stg    = SW'($urandom_range(0, NSTG - 1));
            hzi.ifu_vld    = ($urandom_range(0, 3) != 0);
            hzi.cnt_clr    = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            model_eval();
            e = {m_f, m_s, m_k, m_t};
            n_chk++; if (w_obs !== e) begin n_fail++; $display("FAIL rnd_out cyc %0d got %b want %b", c, w_obs, e); end
            n_chk++; if (hzi.stl_cyc !== CW'(m_stl)) begin n_fail++; $display("FAIL rnd_stl cyc %0d got %0d want %0d", c, hzi.stl_cyc, m_stl); end
            @(posedge clk);
            model_adv();
            #1;
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_branch();
        test_fwd();
        test_mc_done();
        test_mc_tmo();
        test_mc_branch();
        test_reset_mid();
        test_random();
        test_sat_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/u_hz_ctl.md
Name: u_hz_ctl

Overview:
- Parametrised pipeline hazard controller for the RV core. It generates per-stage flush (hzf) and stall (hzs) vectors for an NSTG-stage pipeline, where stage 0 is the IFU.
- Adds sequential behaviour on top of the single-cycle fetch-bubble, branch-flush and forwarding-stall rules:
  - wrong-path drain after a branch redirect;
  - a multi-cycle-unit wait state with watchdog;
  - a stall-cycle performance counter.
- Sits beside the pipeline registers. Its hzf/hzs bits feed each stage's valid/enable logic directly.

Parameters:
- NSTG, 4, number of pipeline stages including the IFU (stage 0); range 3..8.
- SW, $clog2(NSTG), width of stage-index inputs.
- MC_STG, 2, stage holding the multi-cycle unit (mul/div); 1..NSTG-2.
- BR_PEN, 1, extra cycles stage 0 is flushed after a redirect (imem latency); 0..7.
- MC_TMO, 64, watchdog cycles in MCWAIT before forced exit; >=2.
- CW, 16, stall counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ifu_vld  in  1  IFU presents a valid instruction.
- br_vld  in  1  taken branch/jump redirect this cycle.
- br_stg  in  SW  stage resolving the branch.
- fwd_no_dat  in  1  consumer needs data not yet available.
- fwd_stg  in  SW  stage of the waiting consumer.
- mc_start  in  1  multi-cycle op accepted in stage MC_STG.
- mc_done  in  1  multi-cycle result ready.
- cnt_clr  in  1  synchronous clear of stl_cyc.
- hzf  out  NSTG  flush (bubble) stage i this cycle.
- hzs  out  NSTG  hold stage i this cycle.
- mc_kill  out  1  abort the in-flight multi-cycle op.
- mc_tmo  out  1  one-cycle watchdog pulse.
- stl_cyc  out  CW  count of cycles with hzs[0]=1.

Behaviour:
- State machine with states RUN, BRDRN and MCWAIT.
  - Registers: state, a 3-bit drain counter dcnt, a watchdog counter wcnt of $clog2(MC_TMO) bits, and stl_cyc.
  - Reset (async, rst_n=0): state=RUN, dcnt=0, wcnt=0, stl_cyc=0.
- hzf, hzs, mc_kill and mc_tmo are combinational from state and inputs. During reset they follow the RUN-state rules.
- Per-bit resolution: if hzf[i]=1 then hzs[i] is forced to 0 (flush dominates stall).
- Event priority within a cycle: br_vld > MCWAIT hold > mc_start > fwd_no_dat > !ifu_vld.
- RUN state:
  - br_vld: hzf[0..br_stg]=1.
    - BR_PEN>0: next state BRDRN, dcnt=BR_PEN.
  - Else if mc_start:
    - Stage effects: hzs[0..MC_STG]=1, hzf[MC_STG+1]=1.
    - Next state MCWAIT, wcnt=0. If mc_done is also high, stay in RUN (single-cycle op).
  - Else if fwd_no_dat: hzs[0..fwd_stg]=1, hzf[fwd_stg+1]=1. If fwd_stg=NSTG-1, only the stalls apply.
  - Else if !ifu_vld: hzf[1]=1.
- BRDRN state:
  - hzf[0]=1 every cycle; dcnt decrements.
  - dcnt==1: return to RUN next cycle.
  - A new br_vld reloads dcnt=BR_PEN and applies its flush.
  - fwd_no_dat is still evaluated for stages >=1.
- MCWAIT state:
  - Hold: hzs[0..MC_STG]=1, hzf[MC_STG+1]=1; wcnt increments.
  - mc_done: that cycle has no MC stall. Next state RUN.
  - wcnt==MC_TMO-1 without mc_done: mc_tmo=1 and mc_kill=1 for one cycle, no MC stall that cycle, next state RUN.
  - br_vld with br_stg>=MC_STG: hzf[0..br_stg]=1, mc_kill=1, then go to BRDRN (or RUN if BR_PEN=0).
  - br_vld with br_stg<MC_STG: illegal; covered by an assertion, no state change.
- stl_cyc:
  - Increments each cycle hzs[0]=1 and saturates at all-ones.
  - cnt_clr has priority over increment and loads 0.
- Reset asserted mid-MCWAIT or mid-BRDRN returns to RUN immediately; the next cycle starts with no pending drain or wait.

Decomposition:
- Shared package hz_pkg holds:
  - the state enum hz_st_e {RUN, BRDRN, MCWAIT};
  - stage-index constants STG_IFU=0, STG_EX0=1;
  - function stg_mask(idx), returning ones for bits 0..idx.
- No sub-module needed. The counters and FSM fit in one module; stl_cyc may later move into a shared sat_cnt.

Test Plan:
- Reset, ifu_vld=0, nothing else -> hzf=4'b0010, hzs=0, stl_cyc=0.
- br_vld=1, br_stg=1, BR_PEN=2 -> hzf=4'b0011 in the first cycle, then hzf=4'b0001 for 2 cycles, then RUN with hzf=0.
- fwd_no_dat=1, fwd_stg=1 for 3 cycles, then 0 -> hzs=4'b0011 and hzf=4'b0100 each cycle; stl_cyc=3.
- mc_start, then mc_done 5 cycles later -> hzs=4'b0111 and hzf=4'b1000 for 5 cycles; the mc_done cycle has hzs=0; stl_cyc=5.
- mc_start with no mc_done, MC_TMO=8 -> 7 stall cycles, then the 8th cycle gives mc_tmo=1, mc_kill=1, hzs=0; state returns to RUN.
- In MCWAIT, br_vld with br_stg=3 -> hzf=4'b1111, hzs=0, mc_kill=1, then BRDRN. Separately, cnt_clr with stl_cyc at 16'hFFFF -> 0 the next cycle.
